// File: rtl/serial2parallel_rx.sv
// serial2parallel_rx: oversampling receiver for an s_clk / s_clr / s_dat
// serial chain. The three serial lines are synchronised to clk through
// identical flop chains, rising edges of the synced s_clk / s_clr are
// detected, and a small FSM (IDLE / RECV / TAIL) shifts DATA_BITS bits into
// a word that is presented on data with a one-cycle valid strobe.
//
// Handshake: valid and frame_err are single-cycle strobes with no back
// pressure; data is only updated in the cycle valid is high and holds its
// value otherwise. valid and frame_err are never high together.
//
// Optional build macro: S2P_TIMEOUT_EN adds an idle counter that aborts a
// partial frame after TIMEOUT_CYCLES clk cycles without an s_clk rise.
module serial2parallel_rx #(
    parameter int DATA_BITS      = 16,
    parameter int CODE_ENDIAN    = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_clr,
    input  logic                 s_dat,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        TAIL = 2'd2
    } state_t;

    // Reject configurations the datapath cannot support.
    if (DATA_BITS < 2 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("serial2parallel_rx: DATA_BITS, SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
    end

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_d;
    logic                   clr_d;
    logic                   clk_rise;
    logic                   clr_rise;
    logic                   bit_in;
    logic [DATA_BITS-1:0]   sr;
    logic [CW-1:0]          count;
    logic [DATA_BITS-1:0]   restart_sr;
    logic [CW-1:0]          restart_count;
    logic                   timeout_hit;

    // Place one received bit into the word according to the bit order.
    function automatic logic [DATA_BITS-1:0] shift_in(input logic [DATA_BITS-1:0] cur,
                                                      input logic                 b);
        if (CODE_ENDIAN != 0) begin
            return {cur[DATA_BITS-2:0], b};
        end else begin
            return {b, cur[DATA_BITS-1:1]};
        end
    endfunction

    // Identical synchronizer chains keep data aligned with its clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            clr_sync <= '0;
            dat_sync <= '0;
            clk_d    <= 1'b0;
            clr_d    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], s_clk};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], s_clr};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], s_dat};
            clk_d    <= clk_sync[SYNC_STAGES-1];
            clr_d    <= clr_sync[SYNC_STAGES-1];
        end
    end

    assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_d;
    assign clr_rise = clr_sync[SYNC_STAGES-1] & ~clr_d;
    assign bit_in   = dat_sync[SYNC_STAGES-1];

    // Frame restart: clear first, then a coincident s_clk rise becomes bit 0.
    always_comb begin
        restart_sr    = '0;
        restart_count = '0;
        if (clk_rise) begin
            restart_sr    = shift_in('0, bit_in);
            restart_count = CW'(1);
        end
    end

`ifdef S2P_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_cnt;

    // Count clk cycles since the last s_clk rise while a partial frame is open.
    always_ff @(posedge clk) begin
        if (rst || state != RECV || count == '0 || count == FULL || clk_rise || clr_rise) begin
            idle_cnt <= '0;
        end else if (!timeout_hit) begin
            idle_cnt <= idle_cnt + IW'(1);
        end
    end

    assign timeout_hit = (state == RECV) && (count != '0) && (count != FULL) &&
                         (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            count     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    // s_clk rises without a preceding s_clr are ignored here.
                    if (clr_rise) begin
                        state <= RECV;
                        busy  <= 1'b1;
                        sr    <= restart_sr;
                        count <= restart_count;
                    end
                end
                RECV: begin
                    if (count == FULL) begin
                        // Word complete: publish it one cycle after the last bit.
                        data  <= sr;
                        valid <= 1'b1;
                        if (clr_rise) begin
                            sr    <= restart_sr;
                            count <= restart_count;
                        end else begin
                            state <= TAIL;
                            busy  <= 1'b0;
                            count <= '0;
                        end
                    end else if (clr_rise) begin
                        // A clear with bits already collected aborts the frame.
                        if (count != '0) begin
                            frame_err <= 1'b1;
                        end
                        sr    <= restart_sr;
                        count <= restart_count;
                    end else if (clk_rise) begin
                        sr    <= shift_in(sr, bit_in);
                        count <= count + CW'(1);
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        sr        <= '0;
                        count     <= '0;
                    end
                end
                TAIL: begin
                    // Trailing pad rises are ignored; only a clear starts a frame.
                    if (clr_rise) begin
                        state <= RECV;
                        busy  <= 1'b1;
                        sr    <= restart_sr;
                        count <= restart_count;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial2parallel_rx.md
Name: serial2parallel_rx

Overview:
- Receive-side counterpart of the parallel-to-serial converter. Consumes its s_clk / s_clr / s_dat triple and rebuilds the DATA_BITS-wide word.
- Emits the word with a one-cycle valid strobe.
- Used for loopback checking of the serial LED/segment chain and as the shift-in front end for serial input devices.
- Runs on the main clock. The serial lines are oversampled, not used as a clock.

Parameters:
- DATA_BITS, 16, frame payload length in bits (≥2).
- CODE_ENDIAN, 1, 0 = first received bit is LSB; 1 = first received bit is MSB.
- SYNC_STAGES, 2, synchronizer depth on s_clk / s_clr / s_dat (≥2).
- TIMEOUT_CYCLES, 1024, main-clock cycles without an s_clk rise before a partial frame is aborted. Used only with S2P_TIMEOUT_EN.

Ports:
- clk  input  1  main clock
- rst  input  1  reset
- s_clk  input  1  serial clock, async to clk, half-period ≥ 2 clk cycles
- s_clr  input  1  frame-start/clear, high ≥ 2 clk cycles
- s_dat  input  1  serial data, stable around s_clk rising edge
- data  output  DATA_BITS  last completed word
- valid  output  1  one-cycle strobe: data updated
- busy  output  1  frame in progress
- frame_err  output  1  one-cycle strobe: frame aborted

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk and rst).
- Reset values: data=0, valid=0, busy=0, frame_err=0, bit counter=0, shift register=0, synchronizer flops=0.
- Rst asserted mid-frame discards the partial word with no frame_err.
- Synchronization: s_clk, s_clr, s_dat each pass through SYNC_STAGES flops, identical for all three so data/clock alignment is preserved.
- Edge detection: a one-flop delayed copy of the synced s_clk and s_clr gives clk_rise and clr_rise, each one cycle long.
- States: IDLE, RECV, TAIL.
- IDLE:
  - clr_rise → clear shift register and count → RECV, busy=1.
  - s_clk rises in IDLE are ignored.
- RECV, on each clk_rise, shift in synced s_dat:
  - CODE_ENDIAN=1: sr <= {sr[DATA_BITS-2:0], bit}.
  - CODE_ENDIAN=0: sr <= {bit, sr[DATA_BITS-1:1]}.
  - count increments.
- Frame completion: on the rise that makes count == DATA_BITS:
  - next cycle, data <= assembled word and valid=1 for exactly one cycle.
  - → TAIL, busy=0.
  - Latency: valid is high on the (SYNC_STAGES+2)th clk posedge after the first posedge that samples raw s_clk=1 for that bit.
- TAIL:
  - Further s_clk rises (the sender's trailing pad bit) are ignored, no error.
  - clr_rise → clear, RECV (new frame).
- clr_rise in RECV with 1 ≤ count ≤ DATA_BITS-1:
  - frame_err=1 for one cycle, partial word discarded, data unchanged.
  - Restart: count=0, stay RECV.
- clr_rise in RECV with count=0: silent re-arm.
- clr_rise and clk_rise in the same cycle: clear is applied first, then the bit is captured as bit 0, so count=1 afterwards.
  - Required, because the sender raises s_clk once while s_clr is still high, and that rise carries the first bit.
- valid and frame_err are never high in the same cycle.
- data holds its value between frames.

Optional Feature:
- Macro S2P_TIMEOUT_EN.
- Defined:
  - An idle counter runs while in RECV with count ≥ 1 and is cleared on every clk_rise.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulses for 1 cycle, partial word dropped, → IDLE, busy=0.
- Undefined:
  - No counter, no TIMEOUT_CYCLES logic.
  - A partial frame waits indefinitely for more rises or the next s_clr.

Test Plan:
- Loopback with the sender (50/20 MHz defaults, DATA_BITS=16, CODE_ENDIAN=1), send 16'hA5C3 → one valid pulse, data=16'hA5C3, frame_err never asserted, busy low after valid.
- Same loopback with CODE_ENDIAN=0 on both ends, send 16'h0001 then 16'h8000 → two valid pulses, data 16'h0001 then 16'h8000.
- Direct drive: s_clr pulse, 7 bits, then a second s_clr, then a full 16-bit frame of 16'hFFFF → frame_err pulses once at the second s_clr, then valid with data=16'hFFFF.
- Three extra s_clk rises after a completed frame, no s_clr → no valid, no frame_err, data unchanged.
- rst asserted after 10 of 16 bits → all outputs 0 next cycle; a following full frame 16'h1234 gives data=16'h1234.
- With S2P_TIMEOUT_EN and TIMEOUT_CYCLES=64, stop s_clk after 5 bits → frame_err pulses 64 cycles after the last rise, busy=0, state IDLE.
